// File: rtl/uart_io_ctrl_pkg.sv
// Shared types and constants for the UART I/O controller.
// Sequences the CPU in/fin/out byte traffic.
package io_pkg;

   localparam int unsigned RxAwDefault = 12;
   localparam int unsigned ByteW       = 8;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StInWait  = 2'd1,
      StOutWait = 2'd2,
      StAck     = 2'd3
   } io_state_e;

endpackage

// File: rtl/uart_io_ctrl_if.sv
// CPU-side request/acknowledge bundle.
// The core is the master and the controller is the slave.
interface uart_io_ctrl_if;
   import io_pkg::*;

   logic             req_in;
   logic             req_out;
   logic [ByteW-1:0] out_data;
   logic [ByteW-1:0] in_data;
   logic             ack;

   modport master (output req_in, output req_out, output out_data,
                   input in_data, input ack);
   modport slave  (input req_in, input req_out, input out_data,
                   output in_data, output ack);
endinterface

// File: rtl/uart_io_ctrl_rx_fifo.sv
// Single-clock byte FIFO with a separately tracked count.
// Head entry is presented combinationally on dout_o.
module rx_fifo #(
   parameter int unsigned AW = 12,
   parameter int unsigned W  = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic [AW:0]  count_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

   logic [W-1:0]  mem_q [2**AW];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == Depth);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (flush_i)               count_d = '0;
      else if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_io_ctrl.sv
// UART I/O sequencer: buffers received bytes and serves CPU in/out requests
// with a single-cycle ack per request.
module uart_io_ctrl
   import io_pkg::*;
#(
   parameter int unsigned RxAw = RxAwDefault
) (
   input  logic             clk,
   input  logic             rst,
   uart_io_ctrl_if.slave    cpu_if,
   input  logic [ByteW-1:0] rx_data_i,
   input  logic             rx_valid_i,
   output logic [ByteW-1:0] tx_data_o,
   output logic             tx_start_o,
   input  logic             tx_busy_i,
   input  logic             flush_i,
   output logic [RxAw:0]    rx_count_o,
   output logic             rx_overflow_o
);

   io_state_e        state_q, state_d;
   logic             rx_valid_q, overflow_q;
   logic             ack_q, ack_d, tx_start_q, tx_start_d;
   logic [ByteW-1:0] in_data_q, in_data_d, tx_data_q, tx_data_d;
   logic             push, pop, fifo_full, fifo_empty;
   logic [ByteW-1:0] fifo_head;
   logic             can_pop;

   assign push    = rx_valid_i & ~rx_valid_q;
   // A flush in the same cycle empties the FIFO, so nothing can be served.
   assign can_pop = ~fifo_empty & ~flush_i;

   rx_fifo #(.AW(RxAw), .W(ByteW)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush_i),
      .din_i   (rx_data_i),
      .dout_o  (fifo_head),
      .count_o (rx_count_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         rx_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         ack_q      <= 1'b0;
         tx_start_q <= 1'b0;
         in_data_q  <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rx_valid_q <= rx_valid_i;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         in_data_q  <= in_data_d;
         tx_data_q  <= tx_data_d;
         if (flush_i)                overflow_q <= 1'b0;
         else if (push && fifo_full) overflow_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_if.req_in)       state_d = can_pop ? StAck : StInWait;
            else if (cpu_if.req_out) state_d = tx_busy_i ? StOutWait : StAck;
         end
         StInWait:  if (can_pop) state_d = StAck;
         StOutWait: if (!tx_busy_i) state_d = StAck;
         StAck:     if (!cpu_if.req_in && !cpu_if.req_out) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      pop        = 1'b0;
      ack_d      = 1'b0;
      tx_start_d = 1'b0;
      in_data_d  = in_data_q;
      tx_data_d  = tx_data_q;
      unique case (state_q)
         StIdle: begin
            if (cpu_if.req_in) begin
               if (can_pop) begin
                  pop       = 1'b1;
                  in_data_d = fifo_head;
                  ack_d     = 1'b1;
               end
            end else if (cpu_if.req_out && !tx_busy_i) begin
               tx_data_d  = cpu_if.out_data;
               tx_start_d = 1'b1;
               ack_d      = 1'b1;
            end
         end
         StInWait: begin
            if (can_pop) begin
               pop       = 1'b1;
               in_data_d = fifo_head;
               ack_d     = 1'b1;
            end
         end
         StOutWait: begin
            if (!tx_busy_i) begin
               tx_data_d  = cpu_if.out_data;
               tx_start_d = 1'b1;
               ack_d      = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign cpu_if.in_data = in_data_q;
   assign cpu_if.ack     = ack_q;
   assign tx_data_o      = tx_data_q;
   assign tx_start_o     = tx_start_q;
   assign rx_overflow_o  = overflow_q;

endmodule
